// File: rtl/rr_arbiter_hold_pkg.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter_hold_pkg
// Description : FSM state encodings for the hold-until-accepted round-robin arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rr_arbiter_hold_pkg;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_HOLD = 1'b1;

endpackage : rr_arbiter_hold_pkg

`default_nettype wire

// File: rtl/pe_lsb.sv
//------------------------------------------------------------------------------
// Module      : pe_lsb
// Description : LSB-first priority encoder with optional one-hot, cold-mask and index outputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pe_lsb #(
  parameter int WIDTH       = 8,
  parameter int USE_ONE_HOT = 1,
  parameter int USE_COLD    = 1,
  parameter int USE_INDEX   = 1
) (
  input  logic [WIDTH-1:0]         vec,
  output logic                     valid,
  output logic [WIDTH-1:0]         one_hot,
  output logic [WIDTH-1:0]         cold,
  output logic [$clog2(WIDTH)-1:0] index
);

  localparam int             IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] w_lsb;
  logic [WIDTH-1:0] w_at_or_below;
  logic [IDX_W-1:0] w_index;

  // Two's-complement isolates the lowest set bit; xor with vec-1 covers it and
  // everything below, so its complement is the "strictly above" mask (0 if vec=0).
  assign w_lsb         = vec & (~vec + c_ONE);
  assign w_at_or_below = vec ^ (vec - c_ONE);
  assign valid         = |vec;

  always_comb begin
    w_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_lsb[i]) w_index = IDX_W'(i);
    end
  end

  if (USE_ONE_HOT != 0) begin : g_one_hot
    assign one_hot = w_lsb;
  end else begin : g_no_one_hot
    assign one_hot = '0;
  end

  if (USE_COLD != 0) begin : g_cold
    assign cold = ~w_at_or_below;
  end else begin : g_no_cold
    assign cold = '0;
  end

  if (USE_INDEX != 0) begin : g_index
    assign index = w_index;
  end else begin : g_no_index
    assign index = '0;
  end

endmodule : pe_lsb

`default_nettype wire

// File: rtl/rr_arbiter_hold.sv
//------------------------------------------------------------------------------
// Module      : rr_arbiter_hold
// Description : Registered round-robin arbiter; grant is held until accepted on valid/ready.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_hold
  import rr_arbiter_hold_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [WIDTH-1:0]         req_vec,
  output logic                     grant_valid,
  output logic [WIDTH-1:0]         grant_one_hot,
  output logic [$clog2(WIDTH)-1:0] grant_index,
  input  logic                     grant_ready
);

  localparam int IDX_W = $clog2(WIDTH);

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_grant_one_hot;
  logic [IDX_W-1:0] r_grant_index;
  logic [WIDTH-1:0] r_rr_mask;

  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] w_grant_one_hot_nxt;
  logic [IDX_W-1:0] w_grant_index_nxt;
  logic [WIDTH-1:0] w_rr_mask_nxt;

  logic             w_m_valid, w_u_valid;
  logic [WIDTH-1:0] w_m_one_hot, w_u_one_hot;
  logic [WIDTH-1:0] w_m_cold, w_u_cold;
  logic [IDX_W-1:0] w_m_index, w_u_index;

  logic [WIDTH-1:0] w_win_one_hot;
  logic [WIDTH-1:0] w_win_cold;
  logic [IDX_W-1:0] w_win_index;

  pe_lsb #(
    .WIDTH      (WIDTH),
    .USE_ONE_HOT(1),
    .USE_COLD   (1),
    .USE_INDEX  (1)
  ) u_pe_masked (
    .vec    (req_vec & r_rr_mask),
    .valid  (w_m_valid),
    .one_hot(w_m_one_hot),
    .cold   (w_m_cold),
    .index  (w_m_index)
  );

  pe_lsb #(
    .WIDTH      (WIDTH),
    .USE_ONE_HOT(1),
    .USE_COLD   (1),
    .USE_INDEX  (1)
  ) u_pe_unmasked (
    .vec    (req_vec),
    .valid  (w_u_valid),
    .one_hot(w_u_one_hot),
    .cold   (w_u_cold),
    .index  (w_u_index)
  );

  assign w_win_one_hot = w_m_valid ? w_m_one_hot : w_u_one_hot;
  assign w_win_cold    = w_m_valid ? w_m_cold    : w_u_cold;
  assign w_win_index   = w_m_valid ? w_m_index   : w_u_index;

  // rr_mask is loaded with the winner's cold mask as the grant is registered, so
  // at handshake it already equals the "bits above current winner" mask.
  always_comb begin
    w_state_nxt         = r_state;
    w_grant_one_hot_nxt = r_grant_one_hot;
    w_grant_index_nxt   = r_grant_index;
    w_rr_mask_nxt       = r_rr_mask;
    if ((r_state == c_ST_IDLE) || grant_ready) begin
      if (w_u_valid) begin
        w_state_nxt         = c_ST_HOLD;
        w_grant_one_hot_nxt = w_win_one_hot;
        w_grant_index_nxt   = w_win_index;
        w_rr_mask_nxt       = w_win_cold;
      end else begin
        w_state_nxt         = c_ST_IDLE;
        w_grant_one_hot_nxt = '0;
        w_grant_index_nxt   = '0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state         <= c_ST_IDLE;
      r_grant_one_hot <= '0;
      r_grant_index   <= '0;
      r_rr_mask       <= '1;
    end else begin
      r_state         <= w_state_nxt;
      r_grant_one_hot <= w_grant_one_hot_nxt;
      r_grant_index   <= w_grant_index_nxt;
      r_rr_mask       <= w_rr_mask_nxt;
    end
  end

  assign grant_valid   = (r_state == c_ST_HOLD);
  assign grant_one_hot = r_grant_one_hot;
  assign grant_index   = r_grant_index;

endmodule : rr_arbiter_hold

`default_nettype wire

// File: doc/rr_arbiter_hold.md
# rr_arbiter_hold

Registered round-robin arbiter built as the sequential consumer of `pe_lsb`. It takes a request vector, selects one requestor per grant using a rotating priority mask, and presents the winner as a registered one-hot grant plus index on a valid/ready handshake. The grant is held stable until it is accepted. Downstream units (issue queues, shared-port muxes) use it wherever fair selection among WIDTH sources is needed.

## Interface
- `WIDTH`, default 8: number of requestors; must be ≥ 2.
- `CLK` input, 1 bit: clock; all state updates on the rising edge.
- `RST` input, 1 bit: synchronous, active-high reset.
- `req_vec` input, WIDTH bits: request per source; bit i means source i requests.
- `grant_valid` output, 1 bit: registered grant present.
- `grant_one_hot` output, WIDTH bits: registered one-hot winner; all zero when `grant_valid`=0.
- `grant_index` output, $clog2(WIDTH) bits: registered winner index; 0 when `grant_valid`=0.
- `grant_ready` input, 1 bit: consumer accepts the grant this cycle.

## Operation
- **State.** The block has two states:
  - IDLE: `grant_valid`=0.
  - HOLD: `grant_valid`=1.
- **Registers:** `grant_one_hot`, `grant_index`, `grant_valid`, and `rr_mask` (WIDTH bits).
- **Arbitration function** pick(mask, req):
  - masked = req & mask.
  - If masked ≠ 0, the winner is the LSB set bit of masked.
  - Otherwise the winner is the LSB set bit of req (wrap-around).
  - If req = 0, there is no winner.
- **IDLE:**
  - If `req_vec` ≠ 0, register pick(`rr_mask`, `req_vec`) and go to HOLD.
  - If `req_vec` = 0, stay in IDLE.
- **HOLD with `grant_ready`=0:**
  - All outputs hold.
  - `req_vec` changes, including withdrawal of the winner's request, are ignored.
- **HOLD with `grant_ready`=1 (handshake):**
  - next_mask = bits strictly above the current winner, i.e. the cold ack mask of `grant_one_hot`.
  - `rr_mask` ← next_mask.
  - If `req_vec` ≠ 0, register pick(next_mask, `req_vec`) and stay in HOLD; this gives back-to-back grants.
  - If `req_vec` = 0, go to IDLE and clear `grant_one_hot` and `grant_index`.
- **Wrap-around.** A winner at index WIDTH-1 makes next_mask all zeros, so the next pick falls back to unmasked LSB priority.
- **Reset values:**
  - `grant_valid`=0, `grant_one_hot`='0, `grant_index`=0.
  - `rr_mask`='1, so source 0 has highest priority after reset.
  - State = IDLE.
- **Reset dominance.** `RST` overrides every other event, including a handshake in the same cycle and a grant in HOLD.
- `grant_ready` is ignored in IDLE.

## Timing
- Latency from `req_vec` sampled in IDLE to `grant_valid`=1 is 1 cycle (visible after the next rising edge).
- Throughput is 1 grant/cycle while `grant_ready`=1 and `req_vec` ≠ 0.
- Outputs are register-driven only: no combinational path from `req_vec` or `grant_ready` to any output.
- `grant_ready` → next grant goes through one pe_lsb pair plus a mux before the registers; this must close timing at WIDTH ≤ 32.

## Structure
- No new shared typedefs or constants; nothing is added to `core_types_pkg`.
- Instantiate sub-module `pe_lsb` twice:
  - one instance on the masked vector, one on the unmasked vector;
  - both with USE_ONE_HOT=1, USE_COLD=1, USE_INDEX=1.
  - The winner's cold mask feeds next_mask directly.
- Keep the two-state FSM and registers in one always_ff block.
- Next-state logic goes in one always_comb block.

## Test plan
All scenarios use WIDTH=8.
- **Reset:**
  - Stimulus: `RST`=1 for 2 cycles with `req_vec`=8'hFF.
  - Required during reset: `grant_valid`=0, `grant_one_hot`=0, `grant_index`=0.
  - Required after release: one cycle later `grant_valid`=1, `grant_index`=0.
- **Round-robin sweep:**
  - Stimulus: `req_vec`=8'hFF, `grant_ready`=1 held.
  - Required: `grant_index` sequence 0,1,2,…,7,0 on consecutive cycles.
- **Backpressure hold:**
  - Stimulus: `req_vec`=8'b00100100, `grant_ready`=0 for 3 cycles, with `req_vec` dropped to 0 during the hold.
  - Required during the hold: `grant_index`=2, `grant_one_hot`=8'b00000100 stable.
  - Required after `grant_ready`=1: next cycle `grant_valid`=0.
- **Skip/fallback:**
  - Stimulus: last winner 2, then `req_vec`=8'b00000110 with `grant_ready`=1.
  - Required: next index 1 (fallback), then index 2.
- **Wrap:**
  - Stimulus: winner 7 accepted, `req_vec`=8'b10000001.
  - Required: next index 0, then 7, then 0.
- **Reset mid-hold:**
  - Stimulus: grant index 5 held with `grant_ready`=0; `RST`=1 for 1 cycle with `grant_ready`=1 in that cycle.
  - Required: `grant_valid`=0 after the edge.
  - Then with `req_vec`=8'b00100001: required index 0 (mask restored to all ones).
